// File: rtl/sample_word_packer.sv
// Packs SW-bit sample beats into DW-bit words for the streamIN FIFO, prefixing each
// capture run with a header word {HDR, run_seq}; words hitting a full FIFO are dropped and counted.
module sample_word_packer #(
  parameter int          DW  = 32,
  parameter int          SW  = 8,
  parameter logic [15:0] HDR = 16'hA55A
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          enable,
  input  logic          sample_valid,
  input  logic [SW-1:0] sample_data,
  input  logic          wfifo_full,
  output logic          wfifo_wr,
  output logic [DW-1:0] wfifo_data,
  input  logic          ovf_clr,
  output logic          ovf_flag,
  output logic [15:0]   ovf_count,
  output logic [15:0]   run_seq
);

  localparam int N    = DW / SW;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_PACK   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [DW-1:0]   pack_q, pack_d;
  logic [15:0]     seq_q, seq_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            flag_q, flag_d;
  logic [15:0]     count_q, count_d;

  logic            emit_s;
  logic [DW-1:0]   word_s;
  logic            drop_s;
  logic            flag_base_s;
  logic [15:0]     count_base_s;

  // Run sequencing, slot packing and word emission decision
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    seq_d   = seq_q;
    emit_s  = 1'b0;
    word_s  = pack_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_HEADER;
        else        state_d = S_IDLE;
      end
      S_HEADER: begin
        emit_s        = 1'b1;
        word_s        = '0;
        word_s[31:0]  = {HDR, seq_q};
        seq_d         = seq_q + 16'd1;
        state_d       = S_PACK;
      end
      S_PACK: begin
        if (!enable) begin
          idx_d   = '0;
          pack_d  = '0;
          state_d = S_IDLE;
        end else if (sample_valid) begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IDXW'(k)) pack_d[k*SW +: SW] = sample_data;
          end
          if (idx_q == IDXW'(N - 1)) begin
            emit_s = 1'b1;
            word_s = pack_d;
            idx_d  = '0;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        idx_d   = '0;
        pack_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Write strobe and overflow accounting; a clear lands before a same-cycle drop
  always_comb begin
    wr_d   = 1'b0;
    data_d = data_q;
    drop_s = 1'b0;
    if (emit_s) begin
      if (!wfifo_full) begin
        wr_d   = 1'b1;
        data_d = word_s;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      drop_s = 1'b0;
    end
    flag_base_s  = ovf_clr ? 1'b0  : flag_q;
    count_base_s = ovf_clr ? 16'd0 : count_q;
    if (drop_s) begin
      flag_d  = 1'b1;
      count_d = (count_base_s == 16'hFFFF) ? count_base_s : count_base_s + 16'd1;
    end else begin
      flag_d  = flag_base_s;
      count_d = count_base_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pack_q  <= '0;
      seq_q   <= 16'd0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      seq_q   <= seq_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      count_q <= count_d;
    end
  end

  assign wfifo_wr   = wr_q;
  assign wfifo_data = data_q;
  assign ovf_flag   = flag_q;
  assign ovf_count  = count_q;
  assign run_seq    = seq_q;

endmodule

// File: tb/tb_sample_word_packer.sv
// Directed bench for sample_word_packer: default 4-beat instance plus a one-beat-per-word
// instance used to reach ovf_count saturation quickly.
module tb_sample_word_packer;

  logic        clk = 1'b0;
  logic        reset_;
  logic        enable, sample_valid, wfifo_full, ovf_clr;
  logic [7:0]  sample_data;
  logic        wfifo_wr, ovf_flag;
  logic [31:0] wfifo_data;
  logic [15:0] ovf_count, run_seq;

  logic        s_enable, s_valid, s_full, s_clr;
  logic [31:0] s_data;
  logic        s_wr, s_flag;
  logic [31:0] s_wdata;
  logic [15:0] s_count, s_seq;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          s_writes = 0;
  logic [31:0] wq[$];
  int          wcyc[$];

  sample_word_packer #(.DW(32), .SW(8), .HDR(16'hA55A)) dut (
    .clk(clk), .reset_(reset_), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .wfifo_full(wfifo_full), .wfifo_wr(wfifo_wr),
    .wfifo_data(wfifo_data), .ovf_clr(ovf_clr), .ovf_flag(ovf_flag),
    .ovf_count(ovf_count), .run_seq(run_seq)
  );

  sample_word_packer #(.DW(32), .SW(32), .HDR(16'hA55A)) dut_sat (
    .clk(clk), .reset_(reset_), .enable(s_enable), .sample_valid(s_valid),
    .sample_data(s_data), .wfifo_full(s_full), .wfifo_wr(s_wr),
    .wfifo_data(s_wdata), .ovf_clr(s_clr), .ovf_flag(s_flag),
    .ovf_count(s_count), .run_seq(s_seq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wfifo_wr === 1'b1) begin
      wq.push_back(wfifo_data);
      wcyc.push_back(cyc);
    end
    if (s_wr === 1'b1) s_writes <= s_writes + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    enable = 1'b0; sample_valid = 1'b0; sample_data = 8'h00; wfifo_full = 1'b0; ovf_clr = 1'b0;
    s_enable = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_full = 1'b0; s_clr = 1'b0;
    step();
    step();
    reset_ = 1'b1;
    step();
  endtask

  task automatic start_run();
    enable = 1'b1;
    step();
    step();
  endtask

  task automatic beat(input logic [7:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    int base;
    int gap_bad;
    int s_base;
    logic [31:0] exp_w;

    // T1: reset state and basic packing
    reset_ = 1'b0;
    enable = 1'b0; sample_valid = 1'b0; sample_data = 8'h00; wfifo_full = 1'b0; ovf_clr = 1'b0;
    s_enable = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_full = 1'b0; s_clr = 1'b0;
    step();
    check_val("rst_wr",    32'(wfifo_wr),   32'h0);
    check_val("rst_data",  wfifo_data,      32'h0);
    check_val("rst_flag",  32'(ovf_flag),   32'h0);
    check_val("rst_count", 32'(ovf_count),  32'h0);
    check_val("rst_seq",   32'(run_seq),    32'h0);
    reset_ = 1'b1;
    step();
    base = wq.size();
    beat(8'h99);
    start_run();
    check_val("t1_hdr_wr",   32'(wfifo_wr), 32'h1);
    check_val("t1_hdr_data", wfifo_data,    32'hA55A0000);
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      beat(8'(i));
      if (i == 4) check_val("t1_lat_wr", 32'(wfifo_wr), 32'h1);
    end
    step();
    step();
    check_val("t1_nwr",  32'(wq.size() - base), 32'd3);
    if (wq.size() - base >= 3) begin
      check_val("t1_w0", wq[base],     32'hA55A0000);
      check_val("t1_w1", wq[base + 1], 32'h04030201);
      check_val("t1_w2", wq[base + 2], 32'h08070605);
    end
    check_val("t1_seq",  32'(run_seq),  32'h1);
    check_val("t1_hold", wfifo_data,    32'h08070605);
    check_val("t1_idle_wr", 32'(wfifo_wr), 32'h0);

    // Header-cycle beat is ignored: junk in HEADER must not enter slot 0
    do_reset();
    base = wq.size();
    enable = 1'b1;
    step();
    sample_valid = 1'b1; sample_data = 8'hEE;
    step();
    sample_valid = 1'b0;
    beat(8'h31); beat(8'h32); beat(8'h33); beat(8'h34);
    step();
    check_val("hdrbeat_nwr", 32'(wq.size() - base), 32'd2);
    if (wq.size() - base >= 2) check_val("hdrbeat_w1", wq[base + 1], 32'h34333231);

    // T2: enable toggled twice without samples
    do_reset();
    base = wq.size();
    start_run();
    enable = 1'b0;
    step();
    start_run();
    enable = 1'b0;
    step();
    step();
    check_val("t2_nwr", 32'(wq.size() - base), 32'd2);
    if (wq.size() - base >= 2) begin
      check_val("t2_w0", wq[base],     32'hA55A0000);
      check_val("t2_w1", wq[base + 1], 32'hA55A0001);
    end
    check_val("t2_seq", 32'(run_seq), 32'h2);

    // T3: FIFO full when a word completes
    do_reset();
    base = wq.size();
    start_run();
    beat(8'h01); beat(8'h02); beat(8'h03);
    wfifo_full = 1'b1;
    beat(8'h04);
    wfifo_full = 1'b0;
    check_val("t3_nowr",  32'(wfifo_wr),  32'h0);
    check_val("t3_flag",  32'(ovf_flag),  32'h1);
    check_val("t3_count", 32'(ovf_count), 32'h1);
    beat(8'h05); beat(8'h06); beat(8'h07); beat(8'h08);
    step();
    check_val("t3_nwr", 32'(wq.size() - base), 32'd2);
    if (wq.size() - base >= 2) check_val("t3_w1", wq[base + 1], 32'h08070605);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_val("t3_clr_flag",  32'(ovf_flag),  32'h0);
    check_val("t3_clr_count", 32'(ovf_count), 32'h0);

    // T4: partial word discarded on enable=0
    do_reset();
    base = wq.size();
    start_run();
    beat(8'h21); beat(8'h22); beat(8'h23);
    enable = 1'b0;
    sample_valid = 1'b1; sample_data = 8'h24;
    step();
    sample_valid = 1'b0;
    step();
    start_run();
    beat(8'h11); beat(8'h12); beat(8'h13); beat(8'h14);
    step();
    check_val("t4_nwr", 32'(wq.size() - base), 32'd3);
    if (wq.size() - base >= 3) begin
      check_val("t4_w0", wq[base],     32'hA55A0000);
      check_val("t4_w1", wq[base + 1], 32'hA55A0001);
      check_val("t4_w2", wq[base + 2], 32'h14131211);
    end
    enable = 1'b0;
    step();

    // T5: saturation on the one-beat-per-word instance
    do_reset();
    s_base = s_writes;
    s_enable = 1'b1;
    step();
    step();
    s_full = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h12345678;
    repeat (65535) step();
    check_val("t5_count_ffff", 32'(s_count), 32'h0000FFFF);
    check_val("t5_flag",       32'(s_flag),  32'h1);
    step();
    check_val("t5_count_sat",  32'(s_count), 32'h0000FFFF);
    s_clr = 1'b1;
    step();
    check_val("t5_clr_drop_count", 32'(s_count), 32'h1);
    check_val("t5_clr_drop_flag",  32'(s_flag),  32'h1);
    s_valid = 1'b0;
    step();
    check_val("t5_clr_count", 32'(s_count), 32'h0);
    check_val("t5_clr_flag",  32'(s_flag),  32'h0);
    s_clr = 1'b0; s_full = 1'b0; s_enable = 1'b0;
    step();
    check_val("t5_sat_writes", 32'(s_writes - s_base), 32'd1);

    // T6: continuous stream, then asynchronous reset mid-stream
    do_reset();
    base = wq.size();
    start_run();
    sample_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      sample_data = 8'(i);
      step();
    end
    sample_valid = 1'b0;
    step();
    step();
    check_val("t6_nwr", 32'(wq.size() - base), 32'd101);
    if (wq.size() - base >= 101) begin
      check_val("t6_hdr", wq[base], 32'hA55A0000);
      for (int k = 0; k < 100; k++) begin
        exp_w = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
        check_val($sformatf("t6_w%0d", k), wq[base + 1 + k], exp_w);
      end
      gap_bad = 0;
      for (int j = 1; j <= 100; j++) begin
        if (wcyc[base + j] - wcyc[base + j - 1] != 4) gap_bad++;
      end
      check_val("t6_gaps", 32'(gap_bad), 32'd0);
    end
    start_run();
    for (int i = 0; i < 4; i++) beat(8'(i));
    check_val("t6_pre_wr",   32'(wfifo_wr), 32'h1);
    check_val("t6_pre_data", wfifo_data,    32'h03020100);
    reset_ = 1'b0;
    #1;
    check_val("t6_arst_wr",    32'(wfifo_wr),  32'h0);
    check_val("t6_arst_data",  wfifo_data,     32'h0);
    check_val("t6_arst_seq",   32'(run_seq),   32'h0);
    check_val("t6_arst_flag",  32'(ovf_flag),  32'h0);
    check_val("t6_arst_count", 32'(ovf_count), 32'h0);
    enable = 1'b0;
    step();
    reset_ = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
